// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture controller: FSM state encoding,
// default sensor timing constants, pin polarities and a timer-load helper.
package cmos_pkg;

    typedef enum logic [2:0] {
        ST_PWR_DOWN,
        ST_RESET,
        ST_SETTLE,
        ST_IDLE,
        ST_WAIT_VSYNC,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_T_PWDN   = 1000;
    localparam int unsigned DEF_T_RST    = 1000;
    localparam int unsigned DEF_T_SETTLE = 4096;
    localparam int unsigned DEF_TIMEOUT  = 2000000;

    localparam int TMR_W = 32;

    localparam logic PWDN_ON  = 1'b1;
    localparam logic PWDN_OFF = 1'b0;
    localparam logic RST_ON   = 1'b0;
    localparam logic RST_OFF  = 1'b1;

    // The timer expires when it reads zero, so loading n-1 keeps a state
    // active for exactly n cycles.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus history flop with rise/fall detect.
// Ports: clk, nRst, din (async input), rise/fall (one-cycle edge flags).
module sync_edge (
    input  logic clk,
    input  logic nRst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    // sh[1] is the synchronised level, sh[2] its previous value.
    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/cmos_capture_ctrl.sv
// CMOS sensor power-up sequencer and frame/line capture framer.
// Ports: clk/nRst, async cmos_vsync/cmos_hsync, arm/reinit controls,
// sensor pwdn/cmos_rst, ready, frame/line strobes, cap_en, line_idx,
// frame_done/frame_err status and a led that toggles per frame.
module cmos_capture_ctrl
    import cmos_pkg::*;
#(
    parameter int unsigned T_PWDN    = DEF_T_PWDN,
    parameter int unsigned T_RST     = DEF_T_RST,
    parameter int unsigned T_SETTLE  = DEF_T_SETTLE,
    parameter int          ROW_START = 0,
    parameter int          ROWS      = 480,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int          LINE_W    = 10
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              cmos_vsync,
    input  logic              cmos_hsync,
    input  logic              arm,
    input  logic              reinit,
    output logic              pwdn,
    output logic              cmos_rst,
    output logic              ready,
    output logic              frame_start,
    output logic              column_start,
    output logic              cap_en,
    output logic [LINE_W-1:0] line_idx,
    output logic              frame_done,
    output logic              frame_err,
    output logic              led
);

    localparam int LAST_ROW = ROW_START + ROWS - 1;

    state_t             state, state_nx;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic [LINE_W-1:0]  raw, raw_nx;
    logic [LINE_W-1:0]  idx_nx;
    logic               fs_nx, cs_nx, cap_nx, err_nx, led_nx;
    logic               v_rise, v_fall, h_rise, h_fall;
    logic               tmr_zero, in_win, last_row;

    sync_edge u_vsync (
        .clk  (clk),
        .nRst (nRst),
        .din  (cmos_vsync),
        .rise (v_rise),
        .fall (v_fall)
    );

    sync_edge u_hsync (
        .clk  (clk),
        .nRst (nRst),
        .din  (cmos_hsync),
        .rise (h_rise),
        .fall (h_fall)
    );

    assign tmr_zero   = (tmr == '0);
    assign in_win     = (int'(raw) >= ROW_START) &&
                        (int'(raw) <= LAST_ROW);
    assign last_row   = (int'(raw) == LAST_ROW);
    assign frame_done = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr_zero ? tmr : tmr - 1'b1;
        raw_nx   = raw;
        idx_nx   = line_idx;
        fs_nx    = 1'b0;
        cs_nx    = 1'b0;
        cap_nx   = cap_en;
        err_nx   = frame_err;
        led_nx   = led;
        pwdn     = PWDN_OFF;
        cmos_rst = RST_OFF;
        ready    = 1'b0;

        unique case (state)
            ST_PWR_DOWN: begin
                pwdn     = PWDN_ON;
                cmos_rst = RST_ON;
                if (tmr_zero) begin
                    state_nx = ST_RESET;
                    tmr_nx   = tmr_load(T_RST);
                end
            end
            ST_RESET: begin
                cmos_rst = RST_ON;
                if (tmr_zero) begin
                    state_nx = ST_SETTLE;
                    tmr_nx   = tmr_load(T_SETTLE);
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (arm) begin
                    state_nx = ST_WAIT_VSYNC;
                    tmr_nx   = tmr_load(TIMEOUT);
                end
            end
            ST_WAIT_VSYNC: begin
                ready = 1'b1;
                if (!arm) begin
                    state_nx = ST_IDLE;
                end else if (v_fall) begin
                    state_nx = ST_CAPTURE;
                    fs_nx    = 1'b1;
                    raw_nx   = '0;
                    tmr_nx   = tmr_load(TIMEOUT);
                end else if (tmr_zero) begin
                    state_nx = ST_DONE;
                    err_nx   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                ready = 1'b1;
                // vsync rise beats a coincident hsync rise.
                if (v_rise || tmr_zero) begin
                    state_nx = ST_DONE;
                    err_nx   = 1'b1;
                end else begin
                    if (h_rise && in_win) begin
                        cs_nx  = 1'b1;
                        cap_nx = 1'b1;
                        idx_nx = LINE_W'(int'(raw) - ROW_START);
                    end
                    if (h_fall) begin
                        cap_nx = 1'b0;
                        if (raw != '1) begin
                            raw_nx = raw + 1'b1;
                        end
                        if (last_row) begin
                            state_nx = ST_DONE;
                            err_nx   = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                if (arm) begin
                    state_nx = ST_WAIT_VSYNC;
                    tmr_nx   = tmr_load(TIMEOUT);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_PWR_DOWN;
                tmr_nx   = tmr_load(T_PWDN);
            end
        endcase

        // Abort any frame silently; status from it is discarded.
        if (reinit) begin
            state_nx = ST_PWR_DOWN;
            tmr_nx   = tmr_load(T_PWDN);
            fs_nx    = 1'b0;
            cs_nx    = 1'b0;
            idx_nx   = line_idx;
            err_nx   = frame_err;
        end

        if (state_nx != ST_CAPTURE) begin
            cap_nx = 1'b0;
        end
        if (state_nx == ST_DONE) begin
            led_nx = ~led;
        end
    end

    // The timer leaves reset preloaded for the power-down interval.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= ST_PWR_DOWN;
            tmr          <= tmr_load(T_PWDN);
            raw          <= '0;
            line_idx     <= '0;
            frame_start  <= 1'b0;
            column_start <= 1'b0;
            cap_en       <= 1'b0;
            frame_err    <= 1'b0;
            led          <= 1'b0;
        end else begin
            state        <= state_nx;
            tmr          <= tmr_nx;
            raw          <= raw_nx;
            line_idx     <= idx_nx;
            frame_start  <= fs_nx;
            column_start <= cs_nx;
            cap_en       <= cap_nx;
            frame_err    <= err_nx;
            led          <= led_nx;
        end
    end

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Self-checking bench for cmos_capture_ctrl: power-up table plus
// directed frame, short-frame, timeout, reinit and async-reset sequences.
module tb_cmos_capture_ctrl;

    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          cmos_vsync = 1'b1;
    logic          cmos_hsync = 1'b0;
    logic          arm = 1'b0;
    logic          reinit = 1'b0;
    logic          pwdn, cmos_rst, ready;
    logic          frame_start, column_start, cap_en;
    logic [LW-1:0] line_idx;
    logic          frame_done, frame_err, led;

    always #5 clk = ~clk;

    cmos_capture_ctrl #(
        .T_PWDN    (4),
        .T_RST     (3),
        .T_SETTLE  (5),
        .ROW_START (1),
        .ROWS      (4),
        .TIMEOUT   (50),
        .LINE_W    (LW)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .cmos_vsync   (cmos_vsync),
        .cmos_hsync   (cmos_hsync),
        .arm          (arm),
        .reinit       (reinit),
        .pwdn         (pwdn),
        .cmos_rst     (cmos_rst),
        .ready        (ready),
        .frame_start  (frame_start),
        .column_start (column_start),
        .cap_en       (cap_en),
        .line_idx     (line_idx),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .led          (led)
    );

    int n_chk = 0;
    int n_fail = 0;

    int            n_fs = 0;
    int            n_cs = 0;
    int            n_cap = 0;
    int            n_fd = 0;
    logic          last_err = 1'b0;
    logic [LW-1:0] idx_log[$];

    always @(negedge clk) begin
        if (frame_start) n_fs++;
        if (column_start) begin
            n_cs++;
            idx_log.push_back(line_idx);
        end
        if (cap_en) n_cap++;
        if (frame_done) begin
            n_fd++;
            last_err = frame_err;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int npulse, input bit vrise);
        cmos_vsync = 1'b1;
        repeat (3) tick();
        cmos_vsync = 1'b0;
        repeat (4) tick();
        repeat (npulse) begin
            cmos_hsync = 1'b1;
            repeat (3) tick();
            cmos_hsync = 1'b0;
            repeat (3) tick();
        end
        if (vrise) cmos_vsync = 1'b1;
        repeat (8) tick();
    endtask

    typedef struct {
        logic pw;
        logic rs;
        logic rd;
    } pu_vec_t;

    pu_vec_t pu[14];

    typedef struct {
        string nm;
        int    npulse;
        bit    vrise;
        int    e_cs;
        int    e_cap;
        logic  e_err;
        logic  e_led;
    } fr_vec_t;

    fr_vec_t fr[3];

    int b_fs, b_cs, b_cap, b_fd, cnt;

    initial begin
        // expected pwdn / cmos_rst / ready after k edges from release
        pu[0]  = '{1'b1, 1'b0, 1'b0};
        pu[1]  = '{1'b1, 1'b0, 1'b0};
        pu[2]  = '{1'b1, 1'b0, 1'b0};
        pu[3]  = '{1'b1, 1'b0, 1'b0};
        pu[4]  = '{1'b0, 1'b0, 1'b0};
        pu[5]  = '{1'b0, 1'b0, 1'b0};
        pu[6]  = '{1'b0, 1'b0, 1'b0};
        pu[7]  = '{1'b0, 1'b1, 1'b0};
        pu[8]  = '{1'b0, 1'b1, 1'b0};
        pu[9]  = '{1'b0, 1'b1, 1'b0};
        pu[10] = '{1'b0, 1'b1, 1'b0};
        pu[11] = '{1'b0, 1'b1, 1'b0};
        pu[12] = '{1'b0, 1'b1, 1'b1};
        pu[13] = '{1'b0, 1'b1, 1'b1};

        fr[0] = '{"nom1",  6, 1'b0, 4, 12, 1'b0, 1'b1};
        fr[1] = '{"short", 3, 1'b1, 2,  6, 1'b1, 1'b0};
        fr[2] = '{"nom2",  6, 1'b0, 4, 12, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwdn", pwdn, 1'b1);
        chk("rst_cmos_rst", cmos_rst, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_cap_en", cap_en, 1'b0);
        chk("rst_led", led, 1'b0);
        chk("rst_line_idx", line_idx, '0);
        nRst = 1'b1;

        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            chk($sformatf("pu%0d_pwdn", k), pwdn, pu[k].pw);
            chk($sformatf("pu%0d_rst", k), cmos_rst, pu[k].rs);
            chk($sformatf("pu%0d_ready", k), ready, pu[k].rd);
        end

        arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_fs = n_fs;
            b_cs = n_cs;
            b_cap = n_cap;
            b_fd = n_fd;
            frame(fr[i].npulse, fr[i].vrise);
            chk({fr[i].nm, "_fs"}, n_fs - b_fs, 1);
            chk({fr[i].nm, "_cs"}, n_cs - b_cs, fr[i].e_cs);
            chk({fr[i].nm, "_cap"}, n_cap - b_cap, fr[i].e_cap);
            chk({fr[i].nm, "_fd"}, n_fd - b_fd, 1);
            chk({fr[i].nm, "_err"}, last_err, fr[i].e_err);
            chk({fr[i].nm, "_led"}, led, fr[i].e_led);
            for (int j = 0; j < fr[i].e_cs; j++) begin
                if (b_cs + j < idx_log.size())
                    chk($sformatf("%s_idx%0d", fr[i].nm, j),
                        idx_log[b_cs + j], j);
            end
            chk({fr[i].nm, "_idx_hold"}, line_idx,
                fr[i].e_cs - 1);
        end

        // timeout: vsync held low, no falling edge
        arm = 1'b0;
        repeat (3) tick();
        arm = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!frame_done && cnt < 200);
        chk("to1_cycles", cnt, 51);
        chk("to1_err", frame_err, 1'b1);
        chk("to1_led", led, 1'b0);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!frame_done && cnt < 200);
        chk("to2_cycles", cnt, 51);
        chk("to2_led", led, 1'b1);
        tick();
        chk("to2_ready", ready, 1'b1);
        chk("to2_fd_pulse", frame_done, 1'b0);

        // reinit mid-line
        b_fd = n_fd;
        cmos_vsync = 1'b1;
        repeat (3) tick();
        cmos_vsync = 1'b0;
        repeat (4) tick();
        repeat (2) begin
            cmos_hsync = 1'b1;
            repeat (3) tick();
            cmos_hsync = 1'b0;
            repeat (3) tick();
        end
        cmos_hsync = 1'b1;
        repeat (3) tick();
        chk("ri_cap_before", cap_en, 1'b1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        chk("ri_pwdn", pwdn, 1'b1);
        chk("ri_cmos_rst", cmos_rst, 1'b0);
        chk("ri_cap_en", cap_en, 1'b0);
        chk("ri_ready", ready, 1'b0);
        cmos_hsync = 1'b0;
        repeat (20) tick();
        chk("ri_no_done", n_fd - b_fd, 0);
        chk("ri_ready_again", ready, 1'b1);

        // async reset mid-line
        cmos_vsync = 1'b1;
        repeat (3) tick();
        cmos_vsync = 1'b0;
        repeat (4) tick();
        repeat (2) begin
            cmos_hsync = 1'b1;
            repeat (3) tick();
            cmos_hsync = 1'b0;
            repeat (3) tick();
        end
        cmos_hsync = 1'b1;
        repeat (3) tick();
        chk("ar_cap_before", cap_en, 1'b1);
        chk("ar_idx_before", line_idx, 1);
        #2;
        nRst = 1'b0;
        #1;
        chk("ar_pwdn", pwdn, 1'b1);
        chk("ar_cmos_rst", cmos_rst, 1'b0);
        chk("ar_ready", ready, 1'b0);
        chk("ar_cap_en", cap_en, 1'b0);
        chk("ar_line_idx", line_idx, '0);
        chk("ar_frame_err", frame_err, 1'b0);
        chk("ar_led", led, 1'b0);
        chk("ar_fd", frame_done, 1'b0);
        chk("ar_cs", column_start, 1'b0);
        chk("ar_fs", frame_start, 1'b0);
        cmos_hsync = 1'b0;
        tick();
        nRst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
